hilo_mdu_ctrl: RTL

Control and result-holding stage wrapped around the 32x32 iterative Booth multiplier core. Accepts multiply and HI/LO move operations from the execute stage and drives stable operands into the multiplier core. Waits a fixed number of cycles, then captures the 64-bit product into architectural HI/LO registers. Stalls the pipeline while a multiply is in flight and serves MFHI/MFLO reads with a registered one-cycle response.

---
 rtl/hilo_mdu_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl
//   Control and result-holding stage around an iterative 32x32 multiplier
//   core. It accepts MULT / MFHI / MFLO / MTHI / MTLO from the execute stage
//   and drives registered, stable operands into the core. MUL_LAT cycles after
//   a MULT is accepted, it captures the 64-bit product into HI/LO. The pipeline
//   is stalled while a multiply is in flight. MFHI/MFLO return a registered
//   one-cycle response.
//
// Handshake: a request transfers on a rising edge where op_valid && op_ready.
//   op_ready depends only on FSM state, never on op_valid or op. The requester
//   holds op/op_a/op_b stable until the transfer. stall = op_valid && !op_ready.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   op_valid/op_ready request handshake; op selects the operation
//   op_a, op_b        multiplicand/multiplier, or MTHI/MTLO write data (op_a)
//   stall             combinational pipeline stall
//   busy              multiply in flight
//   mul_a, mul_b      registered operands to the multiplier core
//   mul_ans, mul_of   product and overflow flag from the core
//   rd_data, rd_valid MFHI/MFLO response (rd_valid is a one-cycle pulse)
//   hi, lo            architectural HI/LO
//   of_flag           mul_of captured at the end of the last MULT
module hilo_mdu_ctrl #(
  parameter int unsigned MUL_LAT = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        op_ready,
  output logic        stall,
  output logic        busy,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_ans,
  input  logic        mul_of,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        of_flag
);

  localparam logic [2:0] OP_MULT = 3'b000;
  localparam logic [2:0] OP_MFHI = 3'b001;
  localparam logic [2:0] OP_MFLO = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;

  // Loaded on accept. The WAIT state then lasts exactly MUL_LAT cycles:
  // MUL_LAT-1 decrements, plus the capture cycle at cnt == 0.
  localparam logic [7:0] CNT_LOAD = 8'(MUL_LAT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic       accept;

  assign accept = op_valid && op_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept && op == OP_MULT) state_next = S_WAIT;
      S_WAIT: if (cnt == 8'd0)             state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic. op_ready comes from state only, so the only
  // input-to-output combinational path is op_valid -> stall.
  always_comb begin
    op_ready = (state == S_IDLE);
    busy     = (state == S_WAIT);
    stall    = op_valid && (state != S_IDLE);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 8'd0;
      mul_a    <= 32'd0;
      mul_b    <= 32'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      rd_data  <= 32'd0;
      rd_valid <= 1'b0;
      of_flag  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (state == S_IDLE) begin
        if (accept) begin
          case (op)
            OP_MULT: begin
              mul_a <= op_a;
              mul_b <= op_b;
              cnt   <= CNT_LOAD;
            end
            OP_MFHI: begin
              rd_data  <= hi;
              rd_valid <= 1'b1;
            end
            OP_MFLO: begin
              rd_data  <= lo;
              rd_valid <= 1'b1;
            end
            OP_MTHI: hi <= op_a;
            OP_MTLO: lo <= op_a;
            default: ;  // NOP codes: accepted, no effect
          endcase
        end
      end else begin
        // mul_a/mul_b are not touched here, so they stay stable for the core.
        if (cnt != 8'd0) begin
          cnt <= cnt - 8'd1;
        end else begin
          hi      <= mul_ans[63:32];
          lo      <= mul_ans[31:0];
          of_flag <= mul_of;
        end
      end
    end
  end

endmodule
